// File: rtl/opb_bank_pkg.sv
// Shared types and helpers for the OPB register bank.
// OPB numbers bits MSB-first; ports here are declared [31:0], so OPB bit k is vector bit 31-k.
package opb_bank_pkg;

    localparam int OPB_DW     = 32;
    localparam int OPB_NBYTES = OPB_DW / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // Index width for n words, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Converts a bit-position mask between OPB (MSB = bit 0) and vector numbering.
    function automatic logic [OPB_DW-1:0] bit_rev(input logic [OPB_DW-1:0] v);
        logic [OPB_DW-1:0] r;
        r = '0;
        for (int i = 0; i < OPB_DW; i++) begin
            r[i] = v[OPB_DW-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_bank_word.sv
// One 32-bit bank word: byte-enable write, optional self-clearing pulse, or read-only status pass-through.
// Write lands on the clock edge after we_i; a pulse word returns to zero one cycle later unless rewritten.
module opb_bank_word
    import opb_bank_pkg::*;
#(
    parameter bit          P_RO    = 1'b0,
    parameter bit          P_PULSE = 1'b0,
    parameter logic [31:0] P_RST   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [OPB_NBYTES-1:0] be_i,
    input  logic [OPB_DW-1:0]     wdat_i,
    input  logic [OPB_DW-1:0]     sta_i,
    output logic [OPB_DW-1:0]     q_o,
    output logic [OPB_DW-1:0]     rd_o
);

    generate
        if (P_RO) begin : g_ro
            logic unused_wr;
            assign unused_wr = ^{clk_i, rst_ni, we_i, be_i, wdat_i};
            assign q_o       = '0;
            assign rd_o      = sta_i;
        end else begin : g_rw
            logic [OPB_DW-1:0] word_q;
            logic [OPB_DW-1:0] word_d;
            logic              unused_sta;

            assign unused_sta = ^sta_i;

            // A write in the same cycle beats the pulse clear.
            always_comb begin
                word_d = P_PULSE ? '0 : word_q;
                if (we_i) begin
                    for (int b = 0; b < OPB_NBYTES; b++) begin
                        word_d[8*b +: 8] = be_i[b] ? wdat_i[8*b +: 8] : word_q[8*b +: 8];
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    word_q <= P_RST;
                end else begin
                    word_q <= word_d;
                end
            end

            assign q_o  = word_q;
            assign rd_o = word_q;
        end
    endgenerate

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit words (writable control or read-only status) in one address window.
// xferAck one cycle after select is first seen, held exactly one cycle; next transfer no sooner than 2 cycles later.
module opb_register_bank
    import opb_bank_pkg::*;
#(
    parameter logic [31:0]              C_BASEADDR   = 32'h0100_0300,
    parameter logic [31:0]              C_HIGHADDR   = 32'h0100_03FF,
    parameter int                       C_OPB_AWIDTH = 32,
    parameter int                       C_OPB_DWIDTH = 32,
    parameter int                       C_NUM_REGS   = 8,
    parameter logic [63:0]              C_RO_MASK    = '0,
    parameter logic [63:0]              C_PULSE_MASK = '0,
    parameter logic [C_NUM_REGS*32-1:0] C_RESET_VAL  = '0,
    parameter string                    C_FAMILY     = "virtex5"
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    input  logic [31:0]                OPB_ABus,
    input  logic [3:0]                 OPB_BE,
    input  logic [31:0]                OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [31:0]                Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    input  logic [C_NUM_REGS*32-1:0]   user_data_in,
    output logic [C_NUM_REGS-1:0]      user_wr_stb
);

    localparam int IDXW = idx_width(C_NUM_REGS);

    if (C_OPB_DWIDTH != OPB_DW) begin : g_bad_dw
        $error("opb_register_bank: only a 32-bit OPB data bus is supported");
    end
    if (C_OPB_AWIDTH != 32) begin : g_bad_aw
        $error("opb_register_bank: only a 32-bit OPB address bus is supported");
    end
    if (C_NUM_REGS < 1 || C_NUM_REGS > 64) begin : g_bad_num
        $error("opb_register_bank: C_NUM_REGS must be 1..64");
    end
    if (C_BASEADDR[1:0] != 2'b00) begin : g_bad_base
        $error("opb_register_bank: C_BASEADDR must be word aligned");
    end
    if (C_FAMILY == "") begin : g_bad_family
        $error("opb_register_bank: C_FAMILY must be named");
    end

    // Address decode on the live bus.
    logic            hit;
    logic            in_range;
    logic [31:0]     offset;
    logic [IDXW-1:0] idx;

    assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign offset   = OPB_ABus - C_BASEADDR;
    assign in_range = ({2'b00, offset[31:2]} < 32'(C_NUM_REGS));
    assign idx      = offset[IDXW+1:2];

    logic unused_bus;
    assign unused_bus = ^{OPB_seqAddr, offset[1:0]};

    state_e          state_q;
    logic            xfer_ack_q;
    logic [IDXW-1:0] idx_q;
    logic            in_range_q;
    logic            rnw_q;
    logic [3:0]      be_q;
    logic [31:0]     dat_q;
    logic [31:0]     rd_dat_q;

    logic [OPB_DW-1:0]     rd_w [C_NUM_REGS];
    logic [OPB_DW-1:0]     rd_sel;
    logic [C_NUM_REGS-1:0] we;
    logic                  wr_commit;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == IDXW'(i)) begin
                rd_sel = rd_w[i];
            end
        end
    end

    // Read data (including status words) is captured on the edge that enters ACK.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q    <= ST_IDLE;
            xfer_ack_q <= 1'b0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            rnw_q      <= 1'b0;
            be_q       <= '0;
            dat_q      <= '0;
            rd_dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_q    <= ST_ACK;
                        xfer_ack_q <= 1'b1;
                        idx_q      <= idx;
                        in_range_q <= in_range;
                        rnw_q      <= OPB_RNW;
                        be_q       <= OPB_BE;
                        dat_q      <= OPB_DBus;
                        rd_dat_q   <= (OPB_RNW && in_range) ? rd_sel : '0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    xfer_ack_q <= 1'b0;
                    rd_dat_q   <= '0;
                end
            endcase
        end
    end

    assign wr_commit = (state_q == ST_ACK) && !rnw_q && in_range_q;

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_word
        if (C_PULSE_MASK[i] && !C_RO_MASK[i] && (C_RESET_VAL[32*i +: 32] != 32'h0)) begin : g_bad_pulse_rst
            $error("opb_register_bank: pulse words must reset to zero");
        end

        assign we[i] = wr_commit && (idx_q == IDXW'(i)) && !C_RO_MASK[i];

        opb_bank_word #(
            .P_RO    (C_RO_MASK[i]),
            .P_PULSE (C_PULSE_MASK[i]),
            .P_RST   (C_RO_MASK[i] ? 32'h0 : C_RESET_VAL[32*i +: 32])
        ) u_word (
            .clk_i  (OPB_Clk),
            .rst_ni (OPB_Rst_n),
            .we_i   (we[i]),
            .be_i   (be_q),
            .wdat_i (dat_q),
            .sta_i  (user_data_in[32*i +: 32]),
            .q_o    (user_data_out[32*i +: 32]),
            .rd_o   (rd_w[i])
        );
    end

    assign user_wr_stb = we;
    assign Sl_xferAck  = xfer_ack_q;
    assign Sl_DBus     = rd_dat_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank with a transaction-rule model checked every cycle.
module tb_opb_register_bank;

    localparam logic [31:0]  BASE = 32'h0100_0300;
    localparam logic [31:0]  HIGH = 32'h0100_03FF;
    localparam logic [7:0]   RO_M = 8'h08;
    localparam logic [7:0]   PU_M = 8'h02;
    localparam logic [255:0] RV   = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  abus = '0;
    logic [3:0]   be = '0;
    logic [31:0]  dbus = '0;
    logic         rnw = 1'b0;
    logic         sel = 1'b0;
    logic         seq = 1'b0;
    logic [31:0]  sl_dbus;
    logic         sl_ack, sl_err, sl_retry, sl_tout;
    logic [255:0] uout;
    logic [255:0] udi;
    logic [7:0]   stb;

    int checks = 0;
    int failures = 0;

    opb_register_bank #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (8),
        .C_RO_MASK    (64'(RO_M)),
        .C_PULSE_MASK (64'(PU_M)),
        .C_RESET_VAL  (RV),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_ack),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .user_data_out (uout),
        .user_data_in  (udi),
        .user_wr_stb   (stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: words as the software sees them, plus the one transfer currently being acknowledged.
    logic [31:0] mw [8];
    int          m_expire [8];
    int          cyc = 0;
    logic        m_ack = 1'b0, m_rnw = 1'b0, m_inr = 1'b0;
    int          m_idx = 0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_dat = '0, m_rdata = '0;
    logic        n_ack, n_rnw, n_inr;
    int          n_idx;
    logic [3:0]  n_be;
    logic [31:0] n_dat, n_rdata;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    mw[i]       = RO_M[i] ? 32'h0 : RV[32*i +: 32];
                    m_expire[i] = 0;
                end
                m_ack = 1'b0; m_rnw = 1'b0; m_inr = 1'b0; m_idx = 0; m_rdata = '0;
            end else begin
                // A window hit is acknowledged next cycle unless this cycle was itself an ack.
                n_ack = sel && (abus >= BASE) && (abus <= HIGH) && !m_ack;
                n_rnw = rnw; n_be = be; n_dat = dbus; n_idx = 0; n_inr = 1'b0; n_rdata = '0;
                if (n_ack) begin
                    n_idx = int'((abus - BASE) >> 2);
                    n_inr = (n_idx < 8);
                    if (n_inr && rnw) begin
                        if (RO_M[n_idx]) n_rdata = udi[32*n_idx +: 32];
                        else             n_rdata = mw[n_idx];
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    if (PU_M[i] && m_expire[i] == cyc) mw[i] = 32'h0;
                end
                if (m_ack && !m_rnw && m_inr && !RO_M[m_idx]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_be[b]) mw[m_idx][8*b +: 8] = m_dat[8*b +: 8];
                    end
                    if (PU_M[m_idx]) m_expire[m_idx] = cyc + 1;
                end
                m_ack = n_ack; m_rnw = n_rnw; m_inr = n_inr; m_idx = n_idx;
                m_be = n_be; m_dat = n_dat; m_rdata = n_rdata;
            end
        end
    end

    function automatic logic [255:0] model_words();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = mw[i];
        return r;
    endfunction

    function automatic logic [255:0] reset_words();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = RO_M[i] ? 32'h0 : RV[32*i +: 32];
        return r;
    endfunction

    initial begin
        logic [7:0] exp_stb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ack", 256'(sl_ack), 256'(0));
                chk("rst_dbus", 256'(sl_dbus), 256'(0));
                chk("rst_stb", 256'(stb), 256'(0));
                chk("rst_words", uout, reset_words());
            end else begin
                exp_stb = '0;
                if (m_ack && !m_rnw && m_inr && !RO_M[m_idx]) exp_stb[m_idx] = 1'b1;
                chk("ack", 256'(sl_ack), 256'(m_ack));
                chk("dbus", 256'(sl_dbus), 256'((m_ack && m_rnw) ? m_rdata : 32'h0));
                chk("wr_stb", 256'(stb), 256'(exp_stb));
                chk("words", uout, model_words());
            end
            chk("tieoffs", 256'({sl_err, sl_retry, sl_tout}), 256'(0));
        end
    end

    // One OPB transfer; lat is cycles from first select to ack, -1 if no ack within 8 cycles.
    task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] d, input logic hold,
                        output logic [31:0] rd, output int lat, output logic [7:0] st);
        @(posedge clk); #1;
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        lat = -1; rd = '0; st = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (sl_ack) begin
                lat = c - 1; rd = sl_dbus; st = stb;
                break;
            end
            if (c == 1 && !hold) begin
                @(posedge clk); #1;
                sel = 1'b0;
            end
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; be = '0; dbus = '0; abus = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [7:0]  st;
        int          acks, consec;
        logic        prev;

        for (int i = 0; i < 8; i++) udi[32*i +: 32] = 32'hA5A5_0000 | i;
        udi[127:96] = 32'hCAFEF00D;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_word2", 256'(uout[95:64]), 256'(32'hDEADBEEF));
        chk("reset_word0", 256'(uout[31:0]), 256'(0));
        chk("reset_word3_ro", 256'(uout[127:96]), 256'(0));

        xfer(32'h0100_0308, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("rd_word2", 256'(rd), 256'(32'hDEADBEEF));
        chk("rd_word2_lat", 256'(lat), 256'(1));

        xfer(32'h0100_0300, 1'b0, 4'b1010, 32'h1234_5678, 1'b1, rd, lat, st);
        chk("wr_word0_lat", 256'(lat), 256'(1));
        chk("wr_word0_stb", 256'(st), 256'(8'h01));
        @(negedge clk);
        chk("word0_be_merge", 256'(uout[31:0]), 256'(32'h1200_5600));
        chk("word0_stb_gone", 256'(stb), 256'(0));
        xfer(32'h0100_0300, 1'b1, 4'h0, 32'h0, 1'b1, rd, lat, st);
        chk("rd_word0", 256'(rd), 256'(32'h1200_5600));

        xfer(32'h0100_030C, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("rd_ro_word3", 256'(rd), 256'(32'hCAFEF00D));
        xfer(32'h0100_030C, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1, rd, lat, st);
        chk("wr_ro_lat", 256'(lat), 256'(1));
        chk("wr_ro_stb", 256'(st), 256'(0));
        @(negedge clk);
        chk("ro_word3_out", 256'(uout[127:96]), 256'(0));

        xfer(32'h0100_0308, 1'b0, 4'b0001, 32'h0000_00AA, 1'b1, rd, lat, st);
        chk("wr_word2_stb", 256'(st), 256'(8'h04));
        @(negedge clk);
        chk("word2_low_byte", 256'(uout[95:64]), 256'(32'hDEAD_BEAA));

        xfer(32'h0100_0310, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b1, rd, lat, st);
        chk("wr_be0_stb", 256'(st), 256'(8'h10));
        @(negedge clk);
        chk("word4_unchanged", 256'(uout[159:128]), 256'(0));

        xfer(32'h0100_0304, 1'b0, 4'hF, 32'h0000_0001, 1'b1, rd, lat, st);
        chk("pulse_stb", 256'(st), 256'(8'h02));
        @(negedge clk);
        chk("pulse_high", 256'(uout[63:32]), 256'(1));
        @(negedge clk);
        chk("pulse_cleared", 256'(uout[63:32]), 256'(0));

        xfer(32'h0100_0340, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("rd_idx16_lat", 256'(lat), 256'(1));
        chk("rd_idx16_data", 256'(rd), 256'(0));
        xfer(32'h0100_0400, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("above_window_noack", 256'(lat), 256'(-1));
        xfer(32'h0100_02FC, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("below_window_noack", 256'(lat), 256'(-1));

        xfer(32'h0100_0314, 1'b0, 4'hF, 32'h0000_0055, 1'b0, rd, lat, st);
        chk("short_sel_lat", 256'(lat), 256'(1));
        @(negedge clk);
        chk("short_sel_commit", 256'(uout[191:160]), 256'(32'h55));

        // Select held for four cycles.
        @(posedge clk); #1;
        abus = 32'h0100_0308; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        acks = 0; consec = 0; prev = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sl_ack) begin
                acks++;
                if (prev) consec++;
            end
            prev = sl_ack;
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0;
        chk("b2b_ack_count", 256'(acks), 256'(2));
        chk("b2b_no_consecutive", 256'(consec), 256'(0));

        // Reset asserted in the middle of a write ack.
        @(posedge clk); #1;
        abus = 32'h0100_0300; rnw = 1'b0; be = 4'hF; dbus = 32'hFFFF_FFFF; sel = 1'b1;
        @(posedge clk); #1;
        chk("ack_before_rst", 256'(sl_ack), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("ack_drops_on_rst", 256'(sl_ack), 256'(0));
        chk("stb_drops_on_rst", 256'(stb), 256'(0));
        sel = 1'b0; dbus = '0; abus = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("word0_no_commit", 256'(uout[31:0]), 256'(0));
        xfer(32'h0100_0308, 1'b1, 4'hF, 32'h0, 1'b1, rd, lat, st);
        chk("rd_word2_after_rst", 256'(rd), 256'(32'hDEADBEEF));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
